// File: rtl/demux8_pkg.sv
// Shared definitions for the 8-slot serial demultiplexer/collector.
//   state_t : collector state (HUNT waits for a sync beat, COLLECT fills slots)
//   WORD_W  : assembled word width
//   SLOT_W  : width of the slot index
package demux8_pkg;

  localparam int WORD_W = 8;
  localparam int SLOT_W = 3;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/demux8_collect.sv
// Serial-to-parallel frame collector with a double-buffered output word.
// A beat with in_sync starts a frame in slot 0; eight accepted beats build
// one word, which is handed to the consumer through a valid/ready register.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : data_in/in_sync qualify this cycle
//   data_in    : serial bit for the current slot
//   in_sync    : beat is slot 0 of a new frame
//   data_out   : assembled word (held while out_valid and not taken)
//   out_valid  : data_out holds an unconsumed word
//   out_ready  : consumer accepts data_out this cycle
//   slot       : next slot index to be written (0 while hunting)
//   frame_err  : one-cycle pulse, sync arrived in the middle of a frame
//   overrun    : sticky, a completed word was dropped
//   clr_ovr    : clears overrun
module demux8_collect
  import demux8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              data_in,
  input  logic              in_sync,
  output logic [WORD_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_ovr
);

  state_t              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [WORD_W-1:0]   asm_q;
  logic [WORD_W-1:0]   data_q;
  logic                out_valid_q;
  logic                frame_err_q;
  logic                overrun_q;

  logic [SLOT_W-1:0]   write_slot;
  logic [SLOT_W-1:0]   bit_idx;
  logic [WORD_W-1:0]   asm_next;
  logic                accept;
  logic                frame_done;
  logic                xfer;

  // A sync beat always lands in slot 0 and starts from a cleared assembly
  // register, so bits of an aborted frame can never leak into the next word.
  always_comb begin
    write_slot = in_sync ? '0 : slot_q;
    bit_idx    = MSB_FIRST ? (SLOT_W'(WORD_W - 1) - write_slot) : write_slot;
    asm_next   = in_sync ? '0 : asm_q;
    asm_next[bit_idx] = data_in;
    accept     = in_valid && (in_sync || (state_q == COLLECT));
    frame_done = in_valid && !in_sync && (state_q == COLLECT) &&
                 (slot_q == SLOT_W'(WORD_W - 1));
    xfer       = out_valid_q && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      asm_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // In COLLECT the slot is never 0, so any sync seen there is mid-frame.
      frame_err_q <= in_valid && in_sync && (state_q == COLLECT);

      if (accept) begin
        asm_q <= asm_next;
        if (frame_done) begin
          slot_q  <= '0;
          state_q <= HUNT;
        end else if (in_sync) begin
          slot_q  <= SLOT_W'(1);
          state_q <= COLLECT;
        end else begin
          slot_q  <= slot_q + SLOT_W'(1);
        end
      end

      // The output register can take a new word in the same cycle the old
      // one is transferred, which keeps back-to-back frames bubble-free.
      if (frame_done && (!out_valid_q || xfer)) begin
        data_q      <= asm_next;
        out_valid_q <= 1'b1;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end

      // A fresh drop takes priority over a simultaneous clear.
      if (frame_done && out_valid_q && !xfer) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux8_collect.sv
// Self-checking bench for demux8_collect. Two instances (LSB-first and
// MSB-first) share all inputs and are compared against a frame-level model.
module tb_demux8_collect;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       data_in;
  logic       in_sync;
  logic       out_ready;
  logic       clr_ovr;

  logic [7:0] dout0, dout1;
  logic       ov0, ov1;
  logic [2:0] slot0, slot1;
  logic       ferr0, ferr1;
  logic       ovr0, ovr1;

  int checks;
  int errors;

  // Reference model: the partial frame as a list of bits, plus the
  // expected output-side values.
  bit         fq[$];
  logic       exp_ov;
  logic       exp_ovr;
  logic       exp_ferr;
  logic [7:0] exp_d0;
  logic [7:0] exp_d1;

  demux8_collect #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .in_sync(in_sync), .data_out(dout0), .out_valid(ov0),
    .out_ready(out_ready), .slot(slot0), .frame_err(ferr0),
    .overrun(ovr0), .clr_ovr(clr_ovr)
  );

  demux8_collect #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .in_sync(in_sync), .data_out(dout1), .out_valid(ov1),
    .out_ready(out_ready), .slot(slot1), .frame_err(ferr1),
    .overrun(ovr1), .clr_ovr(clr_ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word built from a complete frame: slot k is bit k, or bit 7-k MSB-first.
  function automatic logic [7:0] packFrame(input bit msb);
    logic [7:0] w;
    w = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (msb) w[7-k] = fq[k];
      else     w[k]   = fq[k];
    end
    return w;
  endfunction

  task automatic modelReset();
    fq.delete();
    exp_ov   = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    exp_d0   = 8'h00;
    exp_d1   = 8'h00;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("data_out_lsb",  dout0,       exp_d0);
    checkValue("data_out_msb",  dout1,       exp_d1);
    checkValue("out_valid_lsb", {7'd0, ov0}, {7'd0, exp_ov});
    checkValue("out_valid_msb", {7'd0, ov1}, {7'd0, exp_ov});
    checkValue("slot_lsb",  {5'd0, slot0}, 8'(fq.size()));
    checkValue("slot_msb",  {5'd0, slot1}, 8'(fq.size()));
    checkValue("frame_err_lsb", {7'd0, ferr0}, {7'd0, exp_ferr});
    checkValue("frame_err_msb", {7'd0, ferr1}, {7'd0, exp_ferr});
    checkValue("overrun_lsb", {7'd0, ovr0}, {7'd0, exp_ovr});
    checkValue("overrun_msb", {7'd0, ovr1}, {7'd0, exp_ovr});
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input logic iv, input logic din,
                               input logic sync, input logic ordy,
                               input logic clr);
    logic       complete;
    logic       xfer;
    logic [7:0] w0, w1;
    in_valid  = iv;
    data_in   = din;
    in_sync   = sync;
    out_ready = ordy;
    clr_ovr   = clr;
    @(posedge clk);
    complete = 1'b0;
    w0 = 8'h00;
    w1 = 8'h00;
    exp_ferr = 1'b0;
    if (iv) begin
      if (sync) begin
        exp_ferr = (fq.size() != 0);
        fq.delete();
        fq.push_back(din);
      end else if (fq.size() != 0) begin
        fq.push_back(din);
        if (fq.size() == 8) begin
          complete = 1'b1;
          w0 = packFrame(1'b0);
          w1 = packFrame(1'b1);
          fq.delete();
        end
      end
    end
    xfer = exp_ov && ordy;
    if (complete && exp_ov && !xfer) exp_ovr = 1'b1;
    else if (clr)                    exp_ovr = 1'b0;
    if (complete && (!exp_ov || xfer)) begin
      exp_ov = 1'b1;
      exp_d0 = w0;
      exp_d1 = w1;
    end else if (xfer) begin
      exp_ov = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  task automatic sendFrame(input logic [7:0] w, input logic ordy);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, w[k], (k == 0), ordy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] abort_word;
    checks = 0;
    errors = 0;
    in_valid = 0; data_in = 0; in_sync = 0; out_ready = 0; clr_ovr = 0;
    rst_n = 1'b1;
    modelReset();

    // Reset values
    #1 rst_n = 1'b0;
    #1 checkOutput();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Beats without sync are ignored
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkValue("hunt_slot", {5'd0, slot0}, 8'h00);
    checkValue("hunt_valid", {7'd0, ov0}, 8'h00);

    // Frame A5, out_valid one cycle after slot-7 beat
    sendFrame(8'hA5, 1'b1);
    checkValue("a5_lsb", dout0, 8'hA5);
    checkValue("a5_msb", dout1, 8'hA5);
    checkValue("a5_valid", {7'd0, ov0}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asymmetric frame shows bit order
    sendFrame(8'h01, 1'b1);
    checkValue("order_lsb", dout0, 8'h01);
    checkValue("order_msb", dout1, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: consumer stalled across two frames
    sendFrame(8'h3C, 1'b0);
    sendFrame(8'hC3, 1'b0);
    checkValue("ovr_hold", dout0, 8'h3C);
    checkValue("ovr_set", {7'd0, ovr0}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("ovr_clr", {7'd0, ovr0}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sync at slot 4 aborts the frame
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, (k == 0), 1'b1, 1'b0);
    checkValue("abort_slot", {5'd0, slot0}, 8'h04);
    abort_word = 8'h5A;
    applyStimulus(1'b1, abort_word[0], 1'b1, 1'b1, 1'b0);
    checkValue("ferr_pulse", {7'd0, ferr0}, 8'h01);
    checkValue("ferr_slot", {5'd0, slot0}, 8'h01);
    applyStimulus(1'b1, abort_word[1], 1'b0, 1'b1, 1'b0);
    checkValue("ferr_end", {7'd0, ferr0}, 8'h00);
    for (int k = 2; k < 8; k++) applyStimulus(1'b1, abort_word[k], 1'b0, 1'b1, 1'b0);
    checkValue("abort_word", dout0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames, no bubble
    sendFrame(8'h11, 1'b1);
    checkValue("b2b_first", dout0, 8'h11);
    sendFrame(8'h22, 1'b1);
    checkValue("b2b_second", dout0, 8'h22);
    checkValue("b2b_valid", {7'd0, ov0}, 8'h01);
    checkValue("b2b_no_ovr", {7'd0, ovr0}, 8'h00);

    // Reset mid-frame with a pending word
    sendFrame(8'h77, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, (k == 0), 1'b0, 1'b0);
    checkValue("pre_rst_slot", {5'd0, slot0}, 8'h05);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkValue("rst_data", dout0, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkValue("post_rst_hunt", {5'd0, slot0}, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0));
    end

    $display("[TB] directed and random phases complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
